mem_io_responder: RTL and testbench



---
 rtl/mem_io_pkg.sv | 10 +
 rtl/sync_ram16.sv | 20 ++
 rtl/mem_io_responder.sv | 113 +++++++++++
 tb/tb_mem_io_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the MAR/MDR memory and I/O responder.
package mem_io_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef logic [15:0] word_t;

  localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/sync_ram16.sv
// Single-port 16-bit word storage: synchronous write, combinational read.
module sync_ram16 #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       din,
  output logic [15:0]       dout
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/mem_io_responder.sv
// Far-end responder for the CPU MAR/MDR interface: word storage plus I/O at IO_ADDR.
// Optional sticky out-of-range flag ACC_ERR when MEM_IO_ACC_ERR_EN is defined.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        MEM_EN,
  input  logic        WE,
  input  logic [15:0] SW,
  output logic [15:0] DATA_TO_CPU,
  output logic        R,
  output logic [15:0] HEX_OUT
`ifdef MEM_IO_ACC_ERR_EN
  , output logic      ACC_ERR
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  word_t            req_addr, req_data;
  logic             req_we;
  logic             capture, commit;
  word_t            cmt_addr, cmt_data;
  logic             cmt_we, is_io, in_range, ram_we;
  word_t            ram_dout;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_EN) begin
          capture    = 1'b1;
          cnt_next   = CNT_W'(LATENCY);
          state_next = (LATENCY == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (!MEM_EN) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the commit edge is also the capture edge, so use live inputs there.
  assign cmt_addr = (state == IDLE) ? MAR : req_addr;
  assign cmt_data = (state == IDLE) ? MDR : req_data;
  assign cmt_we   = (state == IDLE) ? WE  : req_we;

  assign commit   = (state_next == DONE) && (state != DONE);
  assign is_io    = (cmt_addr == IO_ADDR);
  assign in_range = ((cmt_addr >> ADDR_W) == '0) && !is_io;
  assign ram_we   = commit && cmt_we && in_range && !Reset;

  sync_ram16 #(.ADDR_W(ADDR_W)) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (cmt_addr[ADDR_W-1:0]),
    .din  (cmt_data),
    .dout (ram_dout)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_addr    <= '0;
      req_data    <= '0;
      req_we      <= 1'b0;
      DATA_TO_CPU <= '0;
      HEX_OUT     <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        req_addr <= MAR;
        req_data <= MDR;
        req_we   <= WE;
      end
      if (commit) begin
        if (cmt_we) begin
          if (is_io) HEX_OUT <= cmt_data;
        end else begin
          DATA_TO_CPU <= is_io ? SW : (in_range ? ram_dout : '0);
        end
      end
    end
  end

  assign R = (state == DONE);

`ifdef MEM_IO_ACC_ERR_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                      ACC_ERR <= 1'b0;
    else if (commit && !in_range && !is_io) ACC_ERR <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: LATENCY=2 instance plus a LATENCY=0 instance.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mar = '0, mdr = '0, sw = '0;
  logic        we = 1'b0, mem_en = 1'b0, mem_en_z = 1'b0;
  logic [15:0] data_o, hex_o, data_z, hex_z;
  logic        r, r_z;
  logic        acc_err, acc_err_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_io_responder #(.ADDR_W(10), .LATENCY(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(reset), .MAR(mar), .MDR(mdr), .MEM_EN(mem_en), .WE(we), .SW(sw),
    .DATA_TO_CPU(data_o), .R(r), .HEX_OUT(hex_o)
`ifdef MEM_IO_ACC_ERR_EN
    , .ACC_ERR(acc_err)
`endif
  );

  mem_io_responder #(.ADDR_W(10), .LATENCY(0), .IO_ADDR(16'hFFFF)) dut_z (
    .Clk(clk), .Reset(reset), .MAR(mar), .MDR(mdr), .MEM_EN(mem_en_z), .WE(we), .SW(sw),
    .DATA_TO_CPU(data_z), .R(r_z), .HEX_OUT(hex_z)
`ifdef MEM_IO_ACC_ERR_EN
    , .ACC_ERR(acc_err_z)
`endif
  );

`ifndef MEM_IO_ACC_ERR_EN
  assign acc_err   = 1'b0;
  assign acc_err_z = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sw;
    logic [15:0] exp_data;
    logic [15:0] exp_hex;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] hex;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t exp_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns once R is seen (or the bound expires).
  task automatic apply_stimulus(input bit sel, input logic w, input logic [15:0] addr,
                                input logic [15:0] data, input logic [15:0] s,
                                output logic [15:0] got, output int lat);
    mar = addr; mdr = data; we = w; sw = s;
    if (sel) mem_en_z = 1'b1; else mem_en = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if ((sel ? r_z : r) === 1'b1) break;
    end
    got = sel ? data_z : data_o;
  endtask

  task automatic drop_request(input bit sel);
    if (sel) mem_en_z = 1'b0; else mem_en = 1'b0;
    @(negedge clk);
    check_output("r_after_drop", {31'd0, sel ? r_z : r}, 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    int          lat;
    exp_t        e;

    vecs[0]  = '{1'b1, 16'h0012, 16'hBEEF, 16'hDEAD, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0012, 16'h0000, 16'hDEAD, 16'hBEEF, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 16'hFFFF, 16'h1234, 16'hDEAD, 16'h00A5, 16'h1234, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 16'h5555, 16'hDEAD, 16'h00A5, 16'h1234, 1'b0};
    vecs[5]  = '{1'b1, 16'h0400, 16'hAAAA, 16'hDEAD, 16'h00A5, 16'h1234, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 16'hDEAD, 16'h5555, 16'h1234, 1'b1};
    vecs[7]  = '{1'b0, 16'h0400, 16'h0000, 16'hDEAD, 16'h0000, 16'h1234, 1'b1};
    vecs[8]  = '{1'b1, 16'h03FF, 16'h7777, 16'hDEAD, 16'h0000, 16'h1234, 1'b1};
    vecs[9]  = '{1'b0, 16'h03FF, 16'h0000, 16'hDEAD, 16'h7777, 16'h1234, 1'b1};
    vecs[10] = '{1'b0, 16'h8012, 16'h0000, 16'hDEAD, 16'h0000, 16'h1234, 1'b1};
    vecs[11] = '{1'b0, 16'h0012, 16'h0000, 16'hDEAD, 16'hBEEF, 16'h1234, 1'b1};
    vecs[12] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A3C, 16'h5A3C, 16'h1234, 1'b1};

    repeat (2) @(negedge clk);
    check_output("reset_r", {31'd0, r}, 32'd0);
    check_output("reset_data", {16'd0, data_o}, 32'd0);
    check_output("reset_hex", {16'd0, hex_o}, 32'd0);
    check_output("reset_err", {31'd0, acc_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back in the first IDLE cycle after each drop.
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_hex, vecs[i].exp_err, 3});
      apply_stimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sw, got, lat);
      e = exp_q.pop_front();
      check_output($sformatf("vec%0d_latency", i), lat, e.lat);
      check_output($sformatf("vec%0d_data", i), {16'd0, got}, {16'd0, e.data});
      check_output($sformatf("vec%0d_hex", i), {16'd0, hex_o}, {16'd0, e.hex});
`ifdef MEM_IO_ACC_ERR_EN
      check_output($sformatf("vec%0d_acc_err", i), {31'd0, acc_err}, {31'd0, e.err});
`endif
      drop_request(1'b0);
    end

    // Request inputs change during WAIT; captured read of 0x0012 must win.
    mar = 16'h0012; we = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    mar = 16'h0013; we = 1'b1; mdr = 16'hFFFF;
    lat = 1;
    for (int i = 0; i < 20 && r !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    check_output("wait_change_latency", lat, 3);
    check_output("wait_change_data", {16'd0, data_o}, 32'h0000BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output($sformatf("hold%0d_r", i), {31'd0, r}, 32'd1);
      check_output($sformatf("hold%0d_data", i), {16'd0, data_o}, 32'h0000BEEF);
    end
    drop_request(1'b0);
    check_output("data_kept_after_drop", {16'd0, data_o}, 32'h0000BEEF);

    // Async reset during WAIT of a write aborts it.
    apply_stimulus(1'b0, 1'b1, 16'h0020, 16'h1111, 16'h0000, got, lat);
    drop_request(1'b0);
    apply_stimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, got, lat);
    check_output("pre_reset_read", {16'd0, got}, 32'h00001111);
    drop_request(1'b0);
    mar = 16'h0020; mdr = 16'hCAFE; we = 1'b1; mem_en = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_r", {31'd0, r}, 32'd0);
    check_output("async_reset_data", {16'd0, data_o}, 32'd0);
    check_output("async_reset_hex", {16'd0, hex_o}, 32'd0);
    check_output("async_reset_err", {31'd0, acc_err}, 32'd0);
    mem_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back('{16'h1111, 16'h0000, 1'b0, 3});
    apply_stimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, got, lat);
    e = exp_q.pop_front();
    check_output("post_abort_latency", lat, e.lat);
    check_output("post_abort_data", {16'd0, got}, {16'd0, e.data});
    check_output("post_abort_err", {31'd0, acc_err}, {31'd0, e.err});
    drop_request(1'b0);

    // Zero-latency instance: R one cycle after capture.
    exp_q.push_back('{16'h0000, 16'h0000, 1'b0, 1});
    apply_stimulus(1'b1, 1'b1, 16'h0012, 16'h1357, 16'h0000, got, lat);
    e = exp_q.pop_front();
    check_output("lat0_write_latency", lat, e.lat);
    check_output("lat0_write_data", {16'd0, got}, {16'd0, e.data});
    drop_request(1'b1);
    exp_q.push_back('{16'h1357, 16'h0000, 1'b0, 1});
    apply_stimulus(1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0000, got, lat);
    e = exp_q.pop_front();
    check_output("lat0_read_latency", lat, e.lat);
    check_output("lat0_read_data", {16'd0, got}, {16'd0, e.data});
    drop_request(1'b1);
    exp_q.push_back('{16'h0F0F, 16'h0000, 1'b0, 1});
    apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, got, lat);
    e = exp_q.pop_front();
    check_output("lat0_io_latency", lat, e.lat);
    check_output("lat0_io_data", {16'd0, got}, {16'd0, e.data});
    check_output("lat0_hex", {16'd0, hex_z}, {16'd0, e.hex});
    drop_request(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
